// File: rtl/addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor:
// FSM state encoding, counter sizing and saturation bound patterns.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 64;

   function automatic int cntWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Largest positive two's-complement value, right-aligned in a MAX_WIDTH word
   function automatic logic [MAX_WIDTH-1:0] satMax(input int width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_WIDTH-1:0] satMin(input int width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      v[width-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder used as the one shared arithmetic slice.
module full_adder_1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement add/subtract, one result bit per clock.
// Define ADDSUB_SAT_EN to clamp S to the signed range on overflow.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             flag
);

   localparam int CNT_W = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef ADDSUB_SAT_EN
   localparam logic [MAX_WIDTH-1:0] SAT_MAX_FULL = satMax(WIDTH);
   localparam logic [MAX_WIDTH-1:0] SAT_MIN_FULL = satMin(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[WIDTH-1:0];
`endif

   state_t state, nextState;

   logic [WIDTH-1:0] aReg, bReg, sReg, sNext;
   logic [CNT_W-1:0] cnt;
   logic             carry, coReg, flagReg;
   logic             sumBit, carryOut, accept, lastBit;

   full_adder_1b u_fa (
      .a (aReg[0]),
      .b (bReg[0]),
      .ci(carry),
      .s (sumBit),
      .co(carryOut)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // A new request is only taken when no operation is in flight
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) nextState = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               nextState = RUN;
            end else begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign lastBit = (state == RUN) && (cnt == LAST);

   // On the MSB step the operand LSBs hold the operand sign bits
   always_comb begin
      sNext = {sumBit, sReg[WIDTH-1:1]};
`ifdef ADDSUB_SAT_EN
      if (lastBit && (carry ^ carryOut)) sNext = aReg[0] ? SAT_MIN : SAT_MAX;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aReg    <= '0;
         bReg    <= '0;
         sReg    <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         coReg   <= 1'b0;
         flagReg <= 1'b0;
      end else if (accept) begin
         aReg  <= a;
         bReg  <= b ^ {WIDTH{sub}};
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         aReg  <= aReg >> 1;
         bReg  <= bReg >> 1;
         sReg  <= sNext;
         carry <= carryOut;
         cnt   <= cnt + CNT_W'(1);
         if (lastBit) begin
            coReg   <= carryOut;
            flagReg <= carry ^ carryOut;
         end
      end
   end

   assign s    = sReg;
   assign co   = coReg;
   assign flag = flagReg;

endmodule

// File: tb/tb_addsub_serial.sv
// Randomized and directed self-checking bench for addsub_serial against
// a plain-integer arithmetic reference model.
module tb_addsub_serial;

   localparam int W    = 8;
   localparam int MAXS = (1 << (W - 1)) - 1;
   localparam int MINS = -(1 << (W - 1));

   logic         clk = 1'b0;
   logic         rst, start, sub;
   logic [W-1:0] a, b, s;
   logic         busy, done, co, flag;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .s    (s),
      .co   (co),
      .flag (flag)
   );

   // Reference: true integer sum/difference, then range checks
   function automatic void refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic sb, output logic [W-1:0] rs,
                                    output logic rco, output logic rflag);
      int ux, uy, sx, sy, uRes, sRes;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (sb) begin
         uRes = ux - uy;
         sRes = sx - sy;
         rco  = (ux >= uy);
      end else begin
         uRes = ux + uy;
         sRes = sx + sy;
         rco  = (uRes >= (1 << W));
      end
      rflag = (sRes > MAXS) || (sRes < MINS);
      rs    = uRes[W-1:0];
`ifdef ADDSUB_SAT_EN
      if (rflag) rs = (sRes > MAXS) ? W'(MAXS) : W'(MINS);
`endif
   endfunction

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
      start = 1'b1;
      a     = x;
      b     = y;
      sub   = sb;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 4 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk);
      #1;
      checkCount++;
      if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      else passCount++;
      checkCount++;
      if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
      else passCount++;
      checkCount++;
      if (s !== '0) $display("[TB] FAIL reset_s: got %h expected 00", s);
      else passCount++;
      checkCount++;
      if (co !== 1'b0 || flag !== 1'b0)
         $display("[TB] FAIL reset_co_flag: got %b%b expected 00", co, flag);
      else passCount++;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [W-1:0] dA[8]   = '{8'h7F, 8'h80, 8'hFF, 8'h05, 8'h80, 8'h00, 8'h7F, 8'h01};
      logic [W-1:0] dB[8]   = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h80, 8'h00, 8'hFF, 8'hFF};
      logic         dSub[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] es;
      logic         eco, ef;
      int           lat;
      for (int i = 0; i < 8; i++) begin
         refModel(dA[i], dB[i], dSub[i], es, eco, ef);
         launch(dA[i], dB[i], dSub[i]);
         waitDone(lat);
         checkCount++;
         if (lat !== W) $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, W);
         else passCount++;
         checkCount++;
         if (s !== es) $display("[TB] FAIL dir%0d_s: got %h expected %h", i, s, es);
         else passCount++;
         checkCount++;
         if (co !== eco || flag !== ef)
            $display("[TB] FAIL dir%0d_co_flag: got %b%b expected %b%b", i, co, flag, eco, ef);
         else passCount++;
         @(posedge clk);
         #1;
         checkCount++;
         if (done !== 1'b0 || s !== es)
            $display("[TB] FAIL dir%0d_hold: got done=%b s=%h expected done=0 s=%h", i, done, s, es);
         else passCount++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, es;
      logic         sb, eco, ef;
      int           lat;
      for (int i = 0; i < 30; i++) begin
         x  = W'($urandom);
         y  = W'($urandom);
         sb = 1'($urandom);
         refModel(x, y, sb, es, eco, ef);
         launch(x, y, sb);
         waitDone(lat);
         checkCount++;
         if (lat !== W || s !== es || co !== eco || flag !== ef)
            $display("[TB] FAIL rand%0d: got lat=%0d s=%h co=%b flag=%b expected lat=%0d s=%h co=%b flag=%b",
                     i, lat, s, co, flag, W, es, eco, ef);
         else passCount++;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] es;
      logic         eco, ef;
      int           lat;
      refModel(8'h12, 8'h34, 1'b0, es, eco, ef);
      launch(8'h12, 8'h34, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      a     = 8'h55;
      b     = 8'h66;
      sub   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(lat);
      checkCount++;
      if (lat !== W - 4) $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, W - 4);
      else passCount++;
      checkCount++;
      if (s !== es || co !== eco || flag !== ef)
         $display("[TB] FAIL ignore_result: got %h/%b/%b expected %h/%b/%b", s, co, flag, es, eco, ef);
      else passCount++;
      @(posedge clk);
      #1;
      checkCount++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("[TB] FAIL ignore_single_done: got done=%b busy=%b expected 0 0", done, busy);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] es1, es2;
      logic         eco1, ef1, eco2, ef2;
      int           lat1, lat2;
      refModel(8'h05, 8'h03, 1'b1, es1, eco1, ef1);
      refModel(8'h7F, 8'h01, 1'b0, es2, eco2, ef2);
      start = 1'b1;
      a     = 8'h05;
      b     = 8'h03;
      sub   = 1'b1;
      @(posedge clk);
      #1;
      waitDone(lat1);
      checkCount++;
      if (lat1 !== W || busy !== 1'b0)
         $display("[TB] FAIL b2b_first_done: got lat=%0d busy=%b expected lat=%0d busy=0", lat1, busy, W);
      else passCount++;
      checkCount++;
      if (s !== es1 || co !== eco1 || flag !== ef1)
         $display("[TB] FAIL b2b_first_result: got %h/%b/%b expected %h/%b/%b", s, co, flag, es1, eco1, ef1);
      else passCount++;
      a   = 8'h7F;
      b   = 8'h01;
      sub = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkCount++;
      if (done !== 1'b0 || busy !== 1'b1)
         $display("[TB] FAIL b2b_accept: got done=%b busy=%b expected 0 1", done, busy);
      else passCount++;
      waitDone(lat2);
      checkCount++;
      if (lat2 + 1 !== W + 1)
         $display("[TB] FAIL b2b_spacing: got %0d expected %0d", lat2 + 1, W + 1);
      else passCount++;
      checkCount++;
      if (s !== es2 || co !== eco2 || flag !== ef2)
         $display("[TB] FAIL b2b_second_result: got %h/%b/%b expected %h/%b/%b", s, co, flag, es2, eco2, ef2);
      else passCount++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] es;
      logic         eco, ef, sawDone;
      int           lat;
      launch(8'hFF, 8'h00, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("[TB] FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done);
      else passCount++;
      checkCount++;
      if (s !== '0 || co !== 1'b0 || flag !== 1'b0)
         $display("[TB] FAIL midrst_outputs: got %h/%b/%b expected 00/0/0", s, co, flag);
      else passCount++;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      sawDone = 1'b0;
      repeat (W + 4) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) sawDone = 1'b1;
      end
      checkCount++;
      if (sawDone !== 1'b0) $display("[TB] FAIL midrst_no_done: got %b expected 0", sawDone);
      else passCount++;
      refModel(8'h05, 8'h03, 1'b1, es, eco, ef);
      launch(8'h05, 8'h03, 1'b1);
      waitDone(lat);
      checkCount++;
      if (lat !== W || s !== es || co !== eco || flag !== ef)
         $display("[TB] FAIL midrst_recover: got lat=%0d %h/%b/%b expected lat=%0d %h/%b/%b",
                  lat, s, co, flag, W, es, eco, ef);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Bit-serial two's-complement adder/subtractor that produces sum, carry-out and signed-overflow flag over WIDTH clock cycles with a start/done handshake. It is the producing end of the A/B → S/CO/overflow interface used by the lab arithmetic datapath. Results are consumed downstream by overflow checking and display logic. It trades latency for a single 1-bit full adder.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  request; sampled only when not BUSY
- SUB  in  1  0 = A+B, 1 = A−B; sampled with START
- A  in  WIDTH  operand A, two's complement; sampled with START
- B  in  WIDTH  operand B, two's complement; sampled with START
- BUSY  out  1  high while bits are being processed
- DONE  out  1  one-cycle pulse: S/CO/FLAG valid
- S  out  WIDTH  result, held until next accepted START
- CO  out  1  carry out of MSB (for SUB: 1 = no borrow)
- FLAG  out  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE (FSM, binary encoded).
- IDLE/DONE + START=1: latch A; latch B XOR {WIDTH{SUB}}; carry ← SUB; bit counter ← 0; → RUN.
- IDLE/DONE + START=0: DONE → IDLE; IDLE stays.
- RUN: each edge adds the LSBs of the A/B shift registers plus carry; sum bit shifts into S from the MSB side; carry updated; counter increments. Carry into MSB captured when counter = WIDTH−1.
- RUN after WIDTH bits (counter = WIDTH−1 edge): CO ← final carry; FLAG ← carry_into_MSB XOR final carry; → DONE.
- START while RUN ignored (no queueing, no restart).
- S/CO/FLAG change only during RUN; held stable in DONE and IDLE.
- Arithmetic modulo 2^WIDTH; CO not folded into FLAG (FLAG is signed overflow only).

## Timing
- Reset (async, immediate): state IDLE, BUSY=0, DONE=0, S=0, CO=0, FLAG=0, counter=0.
- START sampled at edge 0 → BUSY=1 after edge 0 through edge WIDTH.
- After edge WIDTH: BUSY=0, DONE=1, S/CO/FLAG final. DONE falls after edge WIDTH+1.
- Back-to-back: START=1 during the DONE cycle is accepted; DONE still lasts exactly one cycle; throughput one op per WIDTH+1 cycles.
- Reset mid-RUN: operation abandoned, no DONE pulse, outputs as reset.
- S intermediate values during RUN are partial and not valid.

## Configuration
- ADDSUB_SAT_EN defined: on FLAG=1 in the final RUN edge, S is clamped: positive overflow (MSB of A and effective B both 0) → 2^(WIDTH−1)−1; negative overflow → −2^(WIDTH−1). FLAG and CO still report the unclamped event. No added latency.
- Undefined: S is the wrapped modulo result; no clamp logic present.

## Structure
- Package addsub_pkg: state enum (IDLE, RUN, DONE), counter width constant $clog2(WIDTH), saturation constant helpers.
- Sub-module full_adder_1b (A, B, CI → S, CO), instantiated once for the serial bit slice.

## Test plan
- WIDTH=8, A=0x7F, B=0x01, SUB=0 → after 8 edges DONE=1, S=0x80, CO=0, FLAG=1 (with ADDSUB_SAT_EN: S=0x7F).
- A=0x80, B=0x01, SUB=1 → S=0x7F, CO=1, FLAG=1 (with ADDSUB_SAT_EN: S=0x80).
- A=0xFF, B=0x01, SUB=0 → S=0x00, CO=1, FLAG=0; A=0x05, B=0x03, SUB=1 → S=0x02, CO=1, FLAG=0.
- START pulsed again at RUN cycle 3 with different operands → ignored; first result unchanged, single DONE pulse.
- START held high across DONE cycle → second op accepted, DONE pulses 9 cycles apart, BUSY low only during DONE cycles.
- RST asserted at RUN cycle 4 → all outputs 0 immediately, no DONE; next START completes normally.
